// File: rtl/edge_monitor_pkg.sv
// Shared constants and helpers for the edge_monitor block: record field
// positions and width helpers used by the top level, FIFO and interface.
package edge_monitor_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 8;

    // Duration occupies the low bits of a record, the level sits just above it.
    localparam int DUR_LSB = 0;

    // Bit position of the level flag in a record of the given duration width.
    function automatic int level_bit(input int cnt_w);
        return cnt_w;
    endfunction

    // Most significant duration bit in a record of the given duration width.
    function automatic int dur_msb(input int cnt_w);
        return cnt_w - 1;
    endfunction

    // Width of an occupancy counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/edge_monitor_if.sv
// Readout port of edge_monitor: FWFT record stream plus occupancy and
// overflow status. The monitor is the master (record producer).
interface edge_monitor_if #(
    parameter int CNT_W = edge_monitor_pkg::CNT_W_DEFAULT,
    parameter int DEPTH = edge_monitor_pkg::DEPTH_DEFAULT
);

    logic [CNT_W:0]                                    out_data;
    logic                                              out_valid;
    logic                                              out_ready;
    logic [edge_monitor_pkg::count_width(DEPTH)-1:0]   count;
    logic                                              overflow;

    modport master (
        output out_data,
        output out_valid,
        output count,
        output overflow,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  count,
        input  overflow,
        output out_ready
    );

endinterface

// File: rtl/edge_monitor_sync_fifo.sv
// First-word-fall-through FIFO holding level records. A push into a full
// FIFO is accepted only when a pop frees the head slot in the same cycle;
// otherwise it is reported on drop and the contents stay untouched.
module sync_fifo
    import edge_monitor_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          empty,
    output logic                          drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             empty_s;
    logic             full_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against occupancy and compute the next count.
    always_comb begin
        empty_s     = 1'b0;
        full_s      = 1'b0;
        pop_ok_s    = 1'b0;
        push_ok_s   = 1'b0;
        drop        = 1'b0;
        count_nxt_s = count_r;
        empty_s     = (count_r == {CW{1'b0}});
        full_s      = (count_r == FULL_CNT);
        pop_ok_s    = pop & ~empty_s;
        push_ok_s   = push & (~full_s | pop_ok_s);
        drop        = push & full_s & ~pop_ok_s;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Occupancy and pointers; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
        end
    end

    // Record storage; when full, the write lands in the slot being popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Head record falls through; an empty FIFO presents all zeros.
    always_comb begin
        rd_data = {WIDTH{1'b0}};
        if (!empty_s) begin
            rd_data = mem_r[rd_ptr_r];
        end else begin
            rd_data = {WIDTH{1'b0}};
        end
    end

    assign count = count_r;
    assign empty = empty_s;

endmodule

// File: rtl/edge_monitor.sv
// Observer for a single asynchronous bit: synchronizes it, times each level
// segment in clock cycles (saturating) and queues one {level, duration}
// record per completed segment for readout over a valid/ready port.
module edge_monitor
    import edge_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in,
    input  logic          en,
    edge_monitor_if.master bus
);

    localparam int LEVEL_BIT = level_bit(CNT_W);
    localparam int DUR_MSB   = dur_msb(CNT_W);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic             sync1_r;
    logic             s_r;
    logic             p_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             edge_s;
    logic             push_s;
    logic [CNT_W:0]   push_data_s;
    logic             drop_s;
    logic             fifo_empty_s;
    logic             overflow_r;

    // Two-flop synchronizer plus a history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            s_r     <= 1'b0;
            p_r     <= 1'b0;
        end else begin
            sync1_r <= in;
            s_r     <= sync1_r;
            p_r     <= s_r;
        end
    end

    // Edge detect, saturating increment and record assembly.
    always_comb begin
        edge_s      = 1'b0;
        cnt_inc_s   = cnt_r;
        push_s      = 1'b0;
        push_data_s = {(CNT_W+1){1'b0}};
        edge_s      = s_r ^ p_r;
        if (cnt_r == CNT_SAT) begin
            cnt_inc_s = CNT_SAT;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
        push_s                       = en & edge_s;
        push_data_s[LEVEL_BIT]       = p_r;
        push_data_s[DUR_MSB:DUR_LSB] = cnt_inc_s;
    end

    // Segment length counter; held at 0 while recording is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!en || edge_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_inc_s;
        end
    end

    // Sticky flag for any record lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    sync_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (bus.out_ready),
        .rd_data   (bus.out_data),
        .count     (bus.count),
        .empty     (fifo_empty_s),
        .drop      (drop_s)
    );

    assign bus.out_valid = ~fifo_empty_s;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_edge_monitor.sv
// Scoreboard bench for edge_monitor: directed stimulus pushes hand-computed
// records (and, where timed, their expected appearance cycle) into queues;
// monitors pop and compare whenever a record is handed over.
module tb_edge_monitor;

    logic clk = 1'b0;
    logic reset;
    logic in_s;
    logic en;
    logic en4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [16:0] data;
        int          t;
    } exp_t;

    exp_t       q[$];
    logic [4:0] q4[$];

    edge_monitor_if #(.CNT_W(16), .DEPTH(8)) bus ();
    edge_monitor_if #(.CNT_W(4),  .DEPTH(8)) bus4 ();

    edge_monitor #(.CNT_W(16), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_s),
        .en    (en),
        .bus   (bus)
    );

    edge_monitor #(.CNT_W(4), .DEPTH(8)) dut4 (
        .clk   (clk),
        .reset (reset),
        .in    (in_s),
        .en    (en4),
        .bus   (bus4)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index: equals k between rising edge k and k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Flip the observed input; optionally expect the record it closes.
    task automatic tog(input bit keep, input logic [16:0] data, input bit timed);
        exp_t e;
        in_s = ~in_s;
        if (keep) begin
            e.data = data;
            e.t    = timed ? cyc + 3 : -1;
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        in_s          = 1'b0;
        en            = 1'b0;
        en4           = 1'b0;
        bus.out_ready = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic check_main(input string name, input logic [16:0] data, input logic valid,
                              input logic [3:0] count, input logic ovf);
        check({name, "_data"},     {15'd0, bus.out_data}, {15'd0, data});
        check({name, "_valid"},    {31'd0, bus.out_valid}, {31'd0, valid});
        check({name, "_count"},    {28'd0, bus.count},    {28'd0, count});
        check({name, "_overflow"}, {31'd0, bus.overflow}, {31'd0, ovf});
    endtask

    // Record k (1-based) of a run started with 3 idle cycles then a toggle every 3.
    function automatic logic [16:0] rec(input int k);
        if (k == 1)          return 17'h00006;
        else if (k % 2 == 0) return 17'h10003;
        else                 return 17'h00003;
    endfunction

    // Main monitor: compare every accepted record against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got %0h, expected none", bus.out_data);
            end else begin
                e = q.pop_front();
                check("record_data", {15'd0, bus.out_data}, {15'd0, e.data});
                if (e.t >= 0) begin
                    check("record_latency", cyc, e.t);
                end
            end
        end
    end

    // Narrow-counter monitor (always ready).
    always @(negedge clk) begin
        logic [4:0] e4;
        if (!reset && bus4.out_valid && bus4.out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sat_record: got %0h, expected none", bus4.out_data);
            end else begin
                e4 = q4.pop_front();
                check("sat_record_data", {27'd0, bus4.out_data}, {27'd0, e4});
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        reset          = 1'b1;
        in_s           = 1'b0;
        en             = 1'b0;
        en4            = 1'b0;
        bus.out_ready  = 1'b0;
        bus4.out_ready = 1'b1;
        tick(1);
        check_main("reset_state", 17'h00000, 1'b0, 4'd0, 1'b0);
        tick(1);
        reset = 1'b0;

        // Basic: 20 low, 10 high, 5 low, then high.
        en            = 1'b1;
        bus.out_ready = 1'b1;
        tick(20);
        tog(1'b1, 17'h00017, 1'b1);
        tick(10);
        tog(1'b1, 17'h1000A, 1'b1);
        tick(5);
        tog(1'b1, 17'h00005, 1'b1);
        tick(6);

        // Overflow: 10 edges into an unread 8-deep FIFO.
        do_reset();
        en = 1'b1;
        tick(3);
        for (int k = 1; k <= 10; k++) begin
            tog(k <= 8, rec(k), 1'b0);
            tick(3);
        end
        @(negedge clk);
        check_main("full_overflow", 17'h00006, 1'b1, 4'd8, 1'b1);
        tick(1);
        bus.out_ready = 1'b1;
        tick(9);
        @(negedge clk);
        check_main("drained", 17'h00000, 1'b0, 4'd0, 1'b1);

        // Full FIFO with push and pop in the same cycle.
        do_reset();
        en = 1'b1;
        tick(3);
        for (int k = 1; k <= 8; k++) begin
            tog(1'b1, rec(k), 1'b0);
            tick(3);
        end
        tog(1'b1, 17'h00003, 1'b0);
        tick(2);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_main("full_push_pop", 17'h10003, 1'b1, 4'd8, 1'b0);
        tick(1);
        bus.out_ready = 1'b1;
        tick(9);
        @(negedge clk);
        check_main("push_pop_drained", 17'h00000, 1'b0, 4'd0, 1'b0);

        // Asynchronous reset while full with overflow set.
        tick(1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tog(1'b0, 17'h00000, 1'b0);
            tick(3);
        end
        @(negedge clk);
        check("prefill_count", {28'd0, bus.count}, 32'd8);
        check("prefill_overflow", {31'd0, bus.overflow}, 32'd1);
        tick(1);
        #2;
        reset = 1'b1;
        #1;
        check_main("async_reset", 17'h00000, 1'b0, 4'd0, 1'b0);
        check("async_reset_sat_count", {28'd0, bus4.count}, 32'd0);
        q.delete();
        do_reset();

        // Enable gating: toggles while disabled are ignored.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_s = ~in_s;
            tick(3);
        end
        tick(2);
        @(negedge clk);
        check_main("gated", 17'h00000, 1'b0, 4'd0, 1'b0);
        tick(1);
        en = 1'b1;
        tick(10);
        tog(1'b1, 17'h0000D, 1'b1);
        @(negedge clk);
        check("enable_no_spurious", {28'd0, bus.count}, 32'd0);
        tick(5);

        // Saturation on the 4-bit duration instance.
        do_reset();
        en4 = 1'b1;
        tick(5);
        in_s = 1'b1;
        q4.push_back(5'h08);
        tick(40);
        in_s = 1'b0;
        q4.push_back(5'h1F);
        tick(6);

        check("main_queue_empty", q.size(), 32'd0);
        check("sat_queue_empty", q4.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_monitor.md
# edge_monitor

Synthesizable observer for a single-bit signal, the hardware counterpart of the lab stimulus benches that drive a 1-bit input through a timed 0/1 sequence. It synchronizes the observed line, measures how long each level is held, and queues one record per completed level segment. Each record holds the level and its duration in clock cycles. Sits beside a unit under test so software or a bench can read back the waveform the stimulus produced, through a valid/ready port.

## Interface
- `CNT_W`, 16: duration field width; durations saturate at 2^CNT_W−1.
- `DEPTH`, 8: record FIFO depth; power of 2, ≥2.
- `clk` input 1: single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `in` input 1: observed signal, asynchronous to `clk`.
- `en` input 1: recording enable.
- `out_data` output CNT_W+1: record; bit [CNT_W] = level, bits [CNT_W−1:0] = duration.
- `out_valid` output 1: record available.
- `out_ready` input 1: consumer accepts the record.
- `count` output $clog2(DEPTH)+1: number of queued records.
- `overflow` output 1: sticky; a record was dropped.

## Operation
- Synchronizer: `in` → two flops → `s`. A third flop holds `p` (previous `s`). All three reset to 0. Edge = (`s` != `p`).
- Duration counter `cnt` (CNT_W bits), reset 0.
  - On each `en`=1 cycle without an edge: `cnt` ← min(`cnt`+1, 2^CNT_W−1).
  - On each `en`=1 cycle with an edge: push record {`p`, min(`cnt`+1, 2^CNT_W−1)}, then `cnt` ← 0.
  - The pushed duration is the number of cycles `s` held level `p`.
- `en`=0: no pushes and `cnt` held at 0. `p` still tracks `s`, so enabling never creates a spurious edge. The readout port keeps working.
- FIFO: first-word-fall-through.
  - `out_valid` = (`count` != 0).
  - `out_data` = head record when valid, 0 when empty.
  - Pop when `out_valid` && `out_ready`.
- Full FIFO with a push:
  - If a pop occurs in the same cycle, the push is accepted and `count` is unchanged.
  - Otherwise the record is dropped, `overflow` ← 1, and the FIFO contents are unchanged.
- `overflow` clears only on `reset`.
- Empty FIFO with a push and `out_ready`=1: no pop that cycle, because `out_valid` was 0. The record appears the next cycle.
- Pointers wrap modulo DEPTH. `count` ranges from 0 to DEPTH inclusive.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `count`=0, `overflow`=0. Synchronizer flops, `p`, `cnt`, and FIFO pointers are all 0.
- Latency from an `in` transition to the edge: `s` changes 2 clocks later, and the edge is detected in that same cycle. The record is visible on `out_valid`/`out_data` 1 clock after the push, so 3 clocks from the `in` change.
- An asserted `reset` mid-operation empties the FIFO and drops all in-flight state. After deassertion, the first record's level is 0 and its duration counts from the first enabled cycle.
- Throughput: one push and one pop per cycle.

## Structure
- Shared package/header holds the record field positions (LEVEL_BIT = CNT_W, DUR_MSB/LSB) and the saturation constant.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH). It owns the push/pop, full/empty, `count`, and simultaneous-push-pop-when-full rule.
- The top level owns the synchronizer, edge detect, `cnt`, and `overflow`.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → all outputs 0 before the next `clk` edge, including after a prior full FIFO with `overflow`=1.
- Basic: `en`=1, `out_ready`=1, `in`=0 for 20 cycles, 1 for 10, 0 for 5, then 1 → second record = {1, 10} (`out_data` = 0x1000A for CNT_W=16), third = {0, 5}. Each record appears 3 clocks after its `in` edge.
- Saturation: CNT_W=4, `in` high 40 cycles then low → record {1, 15}.
- Overflow: DEPTH=8, `out_ready`=0, 10 edges → `count`=8, `overflow`=1. Draining yields the first 8 records in order, then `out_valid`=0.
- Full push+pop: FIFO full, `out_ready`=1 in the same cycle as an edge → `count` stays 8, `overflow` stays 0, and the new record is last out.
- Enable gating: `en`=0 while `in` toggles 6 times → `count`=0. Raise `en` with `in` steady → no record until the next `in` edge.
